pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage OTTER core. It merges hazard requests into per-stage register enables and flush (bubble) controls:
  - load-use stall from the hazard unit
  - taken branch/jump resolved in EX
  - instruction-memory and data-memory wait
  - halt/resume
- Owns redirect-while-fetch-busy tracking, the halt drain sequence, the memory-wait watchdog and the stall/flush performance counters.

Parameters:
- WAIT_TIMEOUT, 255, cycles a memory wait may last before BUS_ERR; range 1..65535; 16-bit counter.
- DRAIN_CYCLES, 4, cycles of pipeline drain after a halt request before HALTED asserts; range 1..7.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- CLK in 1: clock, rising edge.
- RST_N in 1: asynchronous, active-low reset.
- LOAD_USE in 1: hazard-unit STALL (load in EX feeds the instruction in DE).
- BR_TAKEN in 1: taken branch/jump resolved in EX this cycle.
- IMEM_BUSY in 1: fetch not returned this cycle.
- DMEM_BUSY in 1: data access in MEM not complete this cycle.
- HALT_REQ in 1: halt request, pulse or level.
- RESUME in 1: leave the halted state.
- PC_EN out 1: PC register load enable.
- FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN out 1 each: pipeline register enables.
- FE_DE_FLUSH, DE_EX_FLUSH out 1 each: load a NOP into that register on this edge.
- HALTED out 1: core drained and stopped.
- BUS_ERR out 1: sticky watchdog error.
- STALL_CNT out CNT_W: count of stall cycles.
- FLUSH_CNT out CNT_W: count of taken redirects.

Behaviour:
- Output types: enables and flushes are combinational from the current state and inputs. State, counters, HALTED and BUS_ERR are registered.
- While RST_N=0:
  - state=RUN
  - all counters 0, HALTED=0, BUS_ERR=0
  - all enables and flushes forced to 0
- Reset mid-wait or mid-drain discards all pending redirect and drain status.
- Default outputs (RUN, no request): all enables 1, flushes 0.
- Priority within RUN (highest first): DMEM_BUSY > BR_TAKEN > LOAD_USE > HALT_REQ > IMEM_BUSY.
- A flush overrides its register's enable: the flush register loads a NOP even if its EN=0.
- RUN state:
  - DMEM_BUSY: all enables 0, no flush. Next state DWAIT.
  - BR_TAKEN: all enables 1, FE_DE_FLUSH=1, DE_EX_FLUSH=1, FLUSH_CNT++.
    - If IMEM_BUSY is also 1, next state REDIRECT; otherwise stay in RUN.
  - LOAD_USE: PC_EN=0, FE_DE_EN=0, DE_EX_FLUSH=1, other enables 1. Stay in RUN; single-cycle bubble.
  - HALT_REQ: PC_EN=0, FE_DE_FLUSH=1, other enables 1. Load drain counter with DRAIN_CYCLES-1; next state DRAIN.
  - IMEM_BUSY: PC_EN=0, FE_DE_FLUSH=1, other enables 1. Next state IWAIT.
- DWAIT state: all enables 0.
  - DMEM_BUSY=0: behave exactly as RUN for this cycle's remaining inputs (including next-state selection).
  - Otherwise stay in DWAIT.
- IWAIT state: as RUN's IMEM_BUSY outputs.
  - DMEM_BUSY has priority: outputs as DWAIT, next state DWAIT.
  - BR_TAKEN while IMEM_BUSY=1: next state REDIRECT.
  - IMEM_BUSY=0: outputs as RUN, next state RUN.
- REDIRECT state: PC_EN=0, FE_DE_FLUSH=1 until IMEM_BUSY=0, which discards the stale fetch.
  - On the cycle IMEM_BUSY falls: PC_EN=0, FE_DE_FLUSH=1 once more. Next state RUN.
  - Further BR_TAKEN is ignored here; EX holds a bubble.
- DRAIN state: PC_EN=0, FE_DE_FLUSH=1, other enables 1. Decrement the counter; at 0, next state HALTED_S.
  - DMEM_BUSY freezes the drain: all enables 0, counter held.
  - BR_TAKEN during drain: FE_DE_FLUSH and DE_EX_FLUSH, PC_EN=0. The target is lost by design; halt wins.
- HALTED_S state: HALTED=1, PC_EN=0, FE_DE_FLUSH=1, other enables 0.
  - RESUME=1: next state RUN, HALTED=0 next cycle.
  - HALT_REQ is ignored in this state.
- Watchdog: a 16-bit counter increments each cycle in DWAIT, IWAIT or REDIRECT and clears on leaving those states.
  - When it reaches WAIT_TIMEOUT: BUS_ERR<=1 (sticky until reset), next state HALTED_S.
  - RESUME with BUS_ERR=1 is ignored.
- STALL_CNT: increments when PC_EN=0 and state is not HALTED_S.
- FLUSH_CNT: increments on each accepted BR_TAKEN (RUN or IWAIT).
- Both counters saturate at all-ones.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum: RUN, DWAIT, IWAIT, REDIRECT, DRAIN, HALTED_S (3-bit)
  - the stage-control struct {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN, FE_DE_FLUSH, DE_EX_FLUSH}
  - constants CTRL_RUN, CTRL_FREEZE, CTRL_BUBBLE_DE, CTRL_BUBBLE_FE
- One sub-module, sat_counter (parameter W, inputs INC and CLR), instantiated for STALL_CNT, FLUSH_CNT and the watchdog.

Test Plan:
- LOAD_USE=1 for 1 cycle in RUN -> PC_EN=0, FE_DE_EN=0, DE_EX_FLUSH=1 that cycle; next cycle all enables 1; STALL_CNT=1.
- BR_TAKEN=1 with IMEM_BUSY=1 for 3 cycles -> FE_DE_FLUSH=1 on all 4 cycles including the release cycle; PC_EN=0 in REDIRECT; FLUSH_CNT=1; RUN afterwards.
- DMEM_BUSY=1 and BR_TAKEN=1 together for 2 cycles, then DMEM_BUSY=0 with BR_TAKEN=1 -> all enables 0 for 2 cycles; flushes only on the release cycle; FLUSH_CNT=1.
- HALT_REQ pulse with DRAIN_CYCLES=4 -> 4 cycles of PC_EN=0 with EX_MEM_EN=1; HALTED=1 on cycle 5; RESUME -> RUN next cycle.
- DMEM_BUSY held with WAIT_TIMEOUT=8 -> BUS_ERR=1 after 8 DWAIT cycles, HALTED=1; RESUME ignored; RST_N low clears both.
- RST_N asserted mid-DRAIN -> all outputs 0 asynchronously; after release, state RUN and counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and stage-control constants for the pipeline sequencer.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DWAIT    = 3'd1,
        IWAIT    = 3'd2,
        REDIRECT = 3'd3,
        DRAIN    = 3'd4,
        HALTED_S = 3'd5
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic fe_de_en;
        logic de_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic fe_de_flush;
        logic de_ex_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN       = 7'b11111_00;
    localparam stage_ctrl_t CTRL_FREEZE    = 7'b00000_00;
    localparam stage_ctrl_t CTRL_BUBBLE_DE = 7'b00111_01;
    localparam stage_ctrl_t CTRL_BUBBLE_FE = 7'b01111_10;
    localparam stage_ctrl_t CTRL_BRANCH    = 7'b11111_11;
    // Everything held, but the fetch slot is still overwritten with a NOP.
    localparam stage_ctrl_t CTRL_FREEZE_FE = 7'b00000_10;

    typedef struct packed {
        stage_ctrl_t ctrl;
        state_e      next;
        logic        flush_inc;
        logic        drain_load;
    } run_dec_t;

    // Request arbitration used whenever the sequencer behaves as in RUN.
    function automatic run_dec_t run_decide(
        input logic dmem_busy,
        input logic br_taken,
        input logic load_use,
        input logic halt_req,
        input logic imem_busy,
        input logic drain_short
    );
        run_dec_t d;
        d.ctrl       = CTRL_RUN;
        d.next       = RUN;
        d.flush_inc  = 1'b0;
        d.drain_load = 1'b0;
        if (dmem_busy) begin
            d.ctrl = CTRL_FREEZE;
            d.next = DWAIT;
        end else if (br_taken) begin
            d.ctrl      = CTRL_BRANCH;
            d.flush_inc = 1'b1;
            d.next      = imem_busy ? REDIRECT : RUN;
        end else if (load_use) begin
            d.ctrl = CTRL_BUBBLE_DE;
        end else if (halt_req) begin
            d.ctrl       = CTRL_BUBBLE_FE;
            d.drain_load = 1'b1;
            d.next       = drain_short ? HALTED_S : DRAIN;
        end else if (imem_busy) begin
            d.ctrl = CTRL_BUBBLE_FE;
            d.next = IWAIT;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         INC,
    input  logic         CLR,
    output logic [W-1:0] CNT
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (INC && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign CNT = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : 5-stage pipeline sequencer merging hazard, redirect, memory-wait
//            and halt requests into per-stage enables and flushes.
// Revision : 1.0
// ============================================================================
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD_USE,
    input  logic             BR_TAKEN,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    input  logic             HALT_REQ,
    input  logic             RESUME,
    output logic             PC_EN,
    output logic             FE_DE_EN,
    output logic             DE_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             FE_DE_FLUSH,
    output logic             DE_EX_FLUSH,
    output logic             HALTED,
    output logic             BUS_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [15:0] c_wd_last     = 16'(WAIT_TIMEOUT - 1);
    localparam logic [2:0]  c_drain_init  = 3'(DRAIN_CYCLES - 1);
    localparam logic        c_drain_short = (DRAIN_CYCLES <= 1);

    state_e      r_state;
    state_e      w_next;
    logic [2:0]  r_drain;
    logic        r_halted;
    logic        r_bus_err;
    stage_ctrl_t w_ctrl;
    stage_ctrl_t w_out;
    run_dec_t    w_run;
    logic        w_use_run;
    logic        w_flush_inc;
    logic        w_drain_load;
    logic        w_drain_dec;
    logic        w_in_wait;
    logic        w_wd_trip;
    logic        w_stall_inc;
    logic [15:0] w_wd_cnt;

    assign w_in_wait   = (r_state == DWAIT) || (r_state == IWAIT) || (r_state == REDIRECT);
    assign w_wd_trip   = w_in_wait && (w_wd_cnt == c_wd_last);
    assign w_stall_inc = !w_ctrl.pc_en && (r_state != HALTED_S);

    always_comb begin
        w_run        = run_decide(DMEM_BUSY, BR_TAKEN, LOAD_USE, HALT_REQ, IMEM_BUSY, c_drain_short);
        w_use_run    = 1'b0;
        w_ctrl       = CTRL_FREEZE;
        w_next       = r_state;
        w_flush_inc  = 1'b0;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        case (r_state)
            RUN: begin
                w_use_run = 1'b1;
            end
            DWAIT: begin
                w_use_run = !DMEM_BUSY;
            end
            IWAIT: begin
                if (DMEM_BUSY) begin
                    w_next = DWAIT;
                end else if (BR_TAKEN || !IMEM_BUSY) begin
                    w_use_run = 1'b1;
                end else begin
                    w_ctrl = CTRL_BUBBLE_FE;
                end
            end
            REDIRECT: begin
                // Keep discarding the fetch slot until the stale fetch returns.
                w_ctrl = DMEM_BUSY ? CTRL_FREEZE_FE : CTRL_BUBBLE_FE;
                if (!IMEM_BUSY) begin
                    w_next = RUN;
                end
            end
            DRAIN: begin
                if (!DMEM_BUSY) begin
                    w_ctrl             = CTRL_BUBBLE_FE;
                    w_ctrl.de_ex_flush = BR_TAKEN;
                    w_drain_dec        = 1'b1;
                    if (r_drain <= 3'd1) begin
                        w_next = HALTED_S;
                    end
                end
            end
            HALTED_S: begin
                w_ctrl = CTRL_FREEZE_FE;
                if (RESUME && !r_bus_err) begin
                    w_next = RUN;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase
        if (w_use_run) begin
            w_ctrl       = w_run.ctrl;
            w_next       = w_run.next;
            w_flush_inc  = w_run.flush_inc;
            w_drain_load = w_run.drain_load;
        end
        if (w_wd_trip) begin
            w_next = HALTED_S;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= RUN;
            r_drain   <= 3'd0;
            r_halted  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALTED_S);
            if (w_drain_load) begin
                r_drain <= c_drain_init;
            end else if (w_drain_dec) begin
                r_drain <= r_drain - 3'd1;
            end
            if (w_wd_trip) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (w_stall_inc),
        .CLR   (1'b0),
        .CNT   (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (w_flush_inc),
        .CLR   (1'b0),
        .CNT   (FLUSH_CNT)
    );

    sat_counter #(.W(16)) u_watchdog (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (w_in_wait),
        .CLR   (!w_in_wait),
        .CNT   (w_wd_cnt)
    );

    // Reset forces every stage to hold, independent of the clock.
    assign w_out = RST_N ? w_ctrl : CTRL_FREEZE;
    assign {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN, FE_DE_FLUSH, DE_EX_FLUSH} = w_out;
    assign HALTED  = r_halted;
    assign BUS_ERR = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Randomized and directed bench for pipe_stall_ctrl with a flag-based
//            behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int WAIT_TIMEOUT = 8;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 8;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic LOAD_USE = 1'b0, BR_TAKEN = 1'b0, IMEM_BUSY = 1'b0;
    logic DMEM_BUSY = 1'b0, HALT_REQ = 1'b0, RESUME = 1'b0;
    logic PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN, FE_DE_FLUSH, DE_EX_FLUSH;
    logic HALTED, BUS_ERR;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one flag per waiting condition plus plain counters.
    bit m_halted, m_redir, m_iwait, m_dwait, m_err;
    int m_drain, m_wd, m_stall, m_flush;

    pipe_stall_ctrl #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .LOAD_USE    (LOAD_USE),
        .BR_TAKEN    (BR_TAKEN),
        .IMEM_BUSY   (IMEM_BUSY),
        .DMEM_BUSY   (DMEM_BUSY),
        .HALT_REQ    (HALT_REQ),
        .RESUME      (RESUME),
        .PC_EN       (PC_EN),
        .FE_DE_EN    (FE_DE_EN),
        .DE_EX_EN    (DE_EX_EN),
        .EX_MEM_EN   (EX_MEM_EN),
        .MEM_WB_EN   (MEM_WB_EN),
        .FE_DE_FLUSH (FE_DE_FLUSH),
        .DE_EX_FLUSH (DE_EX_FLUSH),
        .HALTED      (HALTED),
        .BUS_ERR     (BUS_ERR),
        .STALL_CNT   (STALL_CNT),
        .FLUSH_CNT   (FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_redir = 0; m_iwait = 0; m_dwait = 0; m_err = 0;
        m_drain = 0; m_wd = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check_all_clear(input string tag);
        check_val({tag, "_ctrl"}, 32'({PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN,
                                       FE_DE_FLUSH, DE_EX_FLUSH}), 32'd0);
        check_val({tag, "_halted"}, 32'(HALTED), 32'd0);
        check_val({tag, "_bus_err"}, 32'(BUS_ERR), 32'd0);
        check_val({tag, "_stall"}, 32'(STALL_CNT), 32'd0);
        check_val({tag, "_flush"}, 32'(FLUSH_CNT), 32'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {LOAD_USE, BR_TAKEN, IMEM_BUSY, DMEM_BUSY, HALT_REQ, RESUME} = '0;
        model_reset();
        @(posedge CLK); #1;
        check_all_clear("rst");
        RST_N = 1'b1;
    endtask

    // Drive one cycle of inputs, compare at the falling edge, advance the model.
    task automatic cycle(input bit dmem, input bit br, input bit lu,
                         input bit halt, input bit imem, input bit resume);
        logic [6:0] e;
        bit n_halt, n_redir, n_iw, n_dw, acc_br, in_wait, trip;
        int n_drain;
        DMEM_BUSY = dmem; BR_TAKEN = br; LOAD_USE = lu;
        HALT_REQ = halt; IMEM_BUSY = imem; RESUME = resume;
        @(negedge CLK);
        in_wait = m_dwait || m_iwait || m_redir;
        trip    = in_wait && (m_wd == WAIT_TIMEOUT - 1);
        n_halt = m_halted; n_redir = 0; n_iw = 0; n_dw = 0; n_drain = m_drain; acc_br = 0;
        if (m_halted) begin
            e = 7'b0000010;
            if (resume && !m_err) n_halt = 0;
        end else if (m_drain > 0) begin
            if (dmem) e = 7'b0000000;
            else begin
                e = br ? 7'b0111111 : 7'b0111110;
                n_drain = m_drain - 1;
                if (n_drain == 0) n_halt = 1;
            end
        end else if (m_redir) begin
            e = dmem ? 7'b0000010 : 7'b0111110;
            n_redir = imem;
        end else if (dmem) begin
            e = 7'b0000000; n_dw = 1;
        end else if (m_iwait && imem && !br) begin
            e = 7'b0111110; n_iw = 1;
        end else if (br) begin
            e = 7'b1111111; acc_br = 1; n_redir = imem;
        end else if (lu) begin
            e = 7'b0011101;
        end else if (halt) begin
            e = 7'b0111110;
            if (DRAIN_CYCLES == 1) n_halt = 1;
            else n_drain = DRAIN_CYCLES - 1;
        end else if (imem) begin
            e = 7'b0111110; n_iw = 1;
        end else begin
            e = 7'b1111100;
        end

        check_val("ctrl", 32'({PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN,
                               FE_DE_FLUSH, DE_EX_FLUSH}), 32'(e));
        check_val("halted", 32'(HALTED), 32'(m_halted));
        check_val("bus_err", 32'(BUS_ERR), 32'(m_err));
        check_val("stall_cnt", 32'(STALL_CNT), m_stall);
        check_val("flush_cnt", 32'(FLUSH_CNT), m_flush);

        if (!e[6] && !m_halted && m_stall < CNT_MAX) m_stall++;
        if (acc_br && m_flush < CNT_MAX) m_flush++;
        m_wd = in_wait ? m_wd + 1 : 0;
        if (trip) begin
            m_err = 1; n_halt = 1; n_redir = 0; n_iw = 0; n_dw = 0; n_drain = 0;
        end
        m_halted = n_halt; m_redir = n_redir; m_iwait = n_iw; m_dwait = n_dw; m_drain = n_drain;
        @(posedge CLK); #1;
    endtask

    initial begin
        do_reset();

        // Load-use single bubble.
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("lu_stall_cnt", 32'(STALL_CNT), 32'd1);

        // Taken branch while the fetch is outstanding.
        repeat (3) cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("redir_flush_cnt", 32'(FLUSH_CNT), 32'd1);

        // Branch held behind a data-memory wait.
        repeat (2) cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("dwait_flush_cnt", 32'(FLUSH_CNT), 32'd2);

        // Halt drain, then resume.
        cycle(0, 0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        check_val("drain_halted", 32'(HALTED), 32'd1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Drain with a lost branch and a frozen cycle.
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);

        // Instruction-memory wait, then load-use on release.
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Watchdog on a stuck data access; resume must be ignored.
        repeat (10) cycle(1, 0, 0, 0, 0, 0);
        check_val("wd_bus_err", 32'(BUS_ERR), 32'd1);
        repeat (3) cycle(0, 0, 0, 0, 0, 1);
        check_val("wd_resume_ignored", 32'(HALTED), 32'd1);
        do_reset();

        // Asynchronous reset while draining.
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        LOAD_USE = 1'b1; IMEM_BUSY = 1'b1;
        #2 RST_N = 1'b0;
        #1 check_all_clear("async_rst");
        model_reset();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (3) cycle(0, 0, 0, 0, 0, 0);

        // Stall counter saturation.
        repeat (CNT_MAX + 20) cycle(0, 0, 1, 0, 0, 0);
        check_val("stall_sat", 32'(STALL_CNT), CNT_MAX);

        // Randomized segments; the last one leans on long data waits.
        for (int s = 0; s < 6; s++) begin
            int pd;
            pd = (s == 5) ? 75 : 12;
            do_reset();
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < pd, $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
